// File: rtl/alu_issue_ctrl.sv
// Issue controller that registers one ALU request, holds operands through execution and
// keeps the result for writeback. Define ALU_ISSUE_TIMEOUT_EN to compile in the EXEC timeout.
module alu_issue_ctrl #(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_opa,
  input  logic [BIT_WIDTH-1:0] in_opb,
  input  logic [4:0]           in_op,
  input  logic [4:0]           in_rd,
  output logic [BIT_WIDTH-1:0] AluA,
  output logic [BIT_WIDTH-1:0] AluB,
  output logic [4:0]           alucontrol,
  input  logic                 aludone,
  input  logic [BIT_WIDTH-1:0] alu_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [4:0]           out_rd,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("alu_issue_ctrl: TIMEOUT_CYCLES must lie in 2..65535");
  end

  logic [1:0]           state_q, state_d;
  logic [BIT_WIDTH-1:0] opa_q, opa_d;
  logic [BIT_WIDTH-1:0] opb_q, opb_d;
  logic [4:0]           op_q, op_d;
  logic [4:0]           rd_q, rd_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic                 accept;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // RESP can hand straight over to a new request in the same cycle the result drains.
  assign in_ready   = (state_q == StIdle) | ((state_q == StResp) & out_ready);
  assign accept     = in_valid & in_ready;
  assign busy       = (state_q == StExec) | (state_q == StResp);
  assign out_valid  = (state_q == StResp);
  assign AluA       = opa_q;
  assign AluB       = opb_q;
  assign alucontrol = op_q;
  assign out_data   = data_q;
  // rd_q only changes on accept, which in RESP coincides with the result draining.
  assign out_rd     = rd_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    rd_d    = rd_q;
    data_d  = data_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        if (aludone) begin
          data_d  = alu_result;
          state_d = StResp;
`ifdef ALU_ISSUE_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      StResp: begin
        if (out_ready) state_d = accept ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      opa_d = in_opa;
      opb_d = in_opb;
      op_d  = in_op;
      rd_d  = in_rd;
`ifdef ALU_ISSUE_TIMEOUT_EN
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table plus hand-written sequences, results checked
// through a scoreboard queue. Timeout sequences run when ALU_ISSUE_TIMEOUT_EN is defined.
module tb_alu_issue_ctrl;

  localparam int unsigned W = 32;
  localparam logic [4:0] OpAdd = 5'd0;
  localparam logic [4:0] OpSub = 5'd1;
  localparam logic [4:0] OpAnd = 5'd2;
  localparam logic [4:0] OpXor = 5'd4;
  localparam logic [4:0] OpDiv = 5'd9;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_opa, in_opb;
  logic [4:0]   in_op, in_rd;
  logic [W-1:0] AluA, AluB;
  logic [4:0]   alucontrol;
  logic         aludone;
  logic [W-1:0] alu_result;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [4:0]   out_rd;
  logic         busy;
  logic         timeout_err;

  alu_issue_ctrl #(
    .BIT_WIDTH     (W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opa     (in_opa),
    .in_opb     (in_opb),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .AluA       (AluA),
    .AluB       (AluB),
    .alucontrol (alucontrol),
    .aludone    (aludone),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   op;
    logic [4:0]   rd;
    int           lat;
    int           stall;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   rd;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("out_data", out_data, e.data);
      chk("out_rd", out_rd, e.rd);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_zero"}, {out_valid, busy, timeout_err, |AluA, |AluB, |alucontrol,
                         |out_data, |out_rd}, 0);
  endtask

  // One full transaction: accept, lat idle EXEC cycles, capture, stall, drain.
  task automatic do_op(input vec_t v, input logic junk);
    logic ok;
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1; in_opa = v.a; in_opb = v.b; in_op = v.op; in_rd = v.rd;
    step();
    // Upstream noise while in_ready=0 must not disturb anything.
    in_valid = junk; in_opa = ~v.a; in_opb = ~v.b; in_op = ~v.op; in_rd = ~v.rd;
    chk("exec_entry", {busy, out_valid, in_ready}, 3'b100);
    chk("exec_alu_ops", {AluA, AluB, alucontrol}, {v.a, v.b, v.op});
    ok = 1'b1;
    for (int k = 0; k < v.lat; k++) begin
      aludone = 1'b0;
      step();
      if (AluA !== v.a || AluB !== v.b || alucontrol !== v.op || out_valid !== 1'b0
          || busy !== 1'b1) ok = 1'b0;
    end
    chk("exec_stable", ok, 1);
    aludone = 1'b1; alu_result = v.exp;
    sb.push_back('{v.exp, v.rd});
    step();
    aludone = 1'b1; alu_result = $urandom;
    chk("resp_valid", {out_valid, busy}, 2'b11);
    ok = 1'b1;
    for (int k = 0; k < v.stall; k++) begin
      step();
      alu_result = $urandom;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== v.exp || out_rd !== v.rd
          || AluA !== v.a) ok = 1'b0;
    end
    chk("resp_hold", ok, 1);
    aludone = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("resp_in_ready", in_ready, 1);
    sb_pop_check();
    step();
    out_ready = 1'b0;
    chk("idle_after", {out_valid, busy}, 2'b00);
    chk("alu_ops_held", {AluA, AluB, alucontrol}, {v.a, v.b, v.op});
    aludone = 1'b1;
    step();
    aludone = 1'b0;
    chk("idle_ignores_done", {out_valid, busy}, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{32'd5, 32'd3, OpAdd, 5'd7, 0, 0, 32'd8};
    vecs[1] = '{32'd100, 32'd7, OpDiv, 5'd2, 3, 1, 32'd14};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, OpAdd, 5'd31, 1, 2, 32'd0};
    vecs[3] = '{32'd10, 32'd20, OpSub, 5'd0, 2, 0, 32'hFFFF_FFF6};
    vecs[4] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, OpAnd, 5'd15, 0, 5, 32'h00F0_00F0};
    vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, OpXor, 5'd1, 1, 0, 32'hFFFF_FFFF};

    reset = 1'b1; in_valid = 1'b0; in_opa = '0; in_opb = '0; in_op = '0; in_rd = '0;
    aludone = 1'b0; alu_result = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Single-cycle latency: out_valid exactly two edges after accept.
    in_valid = 1'b1; in_opa = 32'd5; in_opb = 32'd3; in_op = OpAdd; in_rd = 5'd7;
    step();
    in_valid = 1'b0; aludone = 1'b1; alu_result = 32'd8;
    chk("lat_one_edge", out_valid, 0);
    step();
    aludone = 1'b0;
    chk("lat_two_edges", out_valid, 1);
    chk("lat_data", {out_data, out_rd}, {32'd8, 5'd7});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    foreach (vecs[i]) do_op(vecs[i], 1'(i % 2));

`ifndef ALU_ISSUE_TIMEOUT_EN
    v = '{32'd100, 32'd7, OpDiv, 5'd9, 33, 0, 32'd14};
    do_op(v, 1'b1);
    chk("no_timeout_flag", timeout_err, 0);
`endif

    // Back-to-back: drain and accept in the same cycle, no IDLE bubble.
    in_valid = 1'b1; in_opa = 32'd20; in_opb = 32'd22; in_op = OpAdd; in_rd = 5'd3;
    step();
    in_valid = 1'b0; aludone = 1'b1; alu_result = 32'd42;
    sb.push_back('{32'd42, 5'd3});
    step();
    aludone = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("b2b_held", {out_valid, in_ready, out_data}, {1'b1, 1'b0, 32'd42});
    in_valid = 1'b1; in_opa = 32'd9; in_opb = 32'd4; in_op = OpSub; in_rd = 5'd12;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    sb_pop_check();
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_exec", {busy, out_valid}, 2'b10);
    chk("b2b_ops", {AluA, AluB, alucontrol}, {32'd9, 32'd4, OpSub});
    aludone = 1'b1; alu_result = 32'd5;
    sb.push_back('{32'd5, 5'd12});
    step();
    aludone = 1'b0;
    chk("b2b_resp", out_valid, 1);
    out_ready = 1'b1;
    #1;
    sb_pop_check();
    step();
    out_ready = 1'b0;
    chk("b2b_idle", {out_valid, busy}, 2'b00);

    // Reset mid-EXEC drops the operation; a late aludone yields nothing.
    in_valid = 1'b1; in_opa = 32'd77; in_opb = 32'd11; in_op = OpDiv; in_rd = 5'd20;
    step();
    in_valid = 1'b0;
    do_reset();
    check_reset_outputs("rst_exec");
    aludone = 1'b1; alu_result = 32'd7;
    step();
    aludone = 1'b0;
    chk("rst_late_done", {out_valid, busy}, 2'b00);

    // Reset mid-RESP drops the held result.
    in_valid = 1'b1; in_opa = 32'd1; in_opb = 32'd2; in_op = OpAdd; in_rd = 5'd4;
    step();
    in_valid = 1'b0; aludone = 1'b1; alu_result = 32'd3;
    step();
    aludone = 1'b0;
    chk("rst_resp_pre", out_valid, 1);
    do_reset();
    check_reset_outputs("rst_resp");

`ifdef ALU_ISSUE_TIMEOUT_EN
    // Timeout after 4 EXEC cycles without aludone.
    in_valid = 1'b1; in_opa = 32'd50; in_opb = 32'd5; in_op = OpDiv; in_rd = 5'd6;
    step();
    in_valid = 1'b0; aludone = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("to_still_exec", {busy, out_valid, timeout_err}, 3'b100);
    sb.push_back('{32'd0, 5'd6});
    step();
    chk("to_resp", {out_valid, timeout_err}, 2'b11);
    out_ready = 1'b1;
    #1;
    sb_pop_check();
    step();
    out_ready = 1'b0;
    chk("to_sticky", {timeout_err, out_valid}, 2'b10);
    do_reset();
    chk("to_reset_clears", timeout_err, 0);
    // aludone on the timeout edge wins.
    v = '{32'd50, 32'd5, OpDiv, 5'd6, 3, 0, 32'd10};
    do_op(v, 1'b0);
    chk("to_done_wins", timeout_err, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, the operand/result width shared with the ALU.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum EXEC cycles before abort (range 2..65535).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream holds a valid op request.
REQ-007 in_ready  output  1  controller accepts a request this cycle.
REQ-008 in_opa / in_opb  input  BIT_WIDTH each  source operands.
REQ-009 in_op  input  5  ALU control code, passed unmodified.
REQ-010 in_rd  input  5  destination register tag.
REQ-011 AluA / AluB  output  BIT_WIDTH each  ALU source operands.
REQ-012 alucontrol  output  5  ALU control code.
REQ-013 aludone  input  1  ALU completion flag.
REQ-014 alu_result  input  BIT_WIDTH  ALU result.
REQ-015 out_valid  output  1  result is held for writeback.
REQ-016 out_ready  input  1  writeback consumes the result this cycle.
REQ-017 out_data  output  BIT_WIDTH  captured result.
REQ-018 out_rd  output  5  tag of the captured result.
REQ-019 busy  output  1  high in EXEC or RESP.
REQ-020 timeout_err  output  1  sticky abort flag.

Function
REQ-021 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-022 in_ready SHALL be 1 in IDLE, 1 in RESP when out_ready=1, and 0 otherwise.
REQ-023 Accept (in_valid & in_ready) SHALL register in_opa, in_opb, in_op and in_rd, and enter EXEC on the next cycle.
REQ-024 AluA, AluB and alucontrol SHALL be driven from registers and stay stable for the whole of EXEC.
REQ-025 Outside EXEC, AluA, AluB and alucontrol SHALL hold their last values, so no spurious operand toggling reaches the ALU.
REQ-026 In EXEC, aludone=1 at a rising edge SHALL capture alu_result into out_data and enter RESP; minimum latency is accept edge to out_valid = 2 cycles.
REQ-027 aludone SHALL be ignored in IDLE and RESP.
REQ-028 out_valid SHALL be 1 exactly in RESP; out_data and out_rd SHALL stay stable until out_ready=1.
REQ-029 RESP with out_ready=1 and no accept SHALL go to IDLE.
REQ-030 RESP with out_ready=1 and an accept SHALL go directly to EXEC with the new operands (back-to-back; no IDLE bubble).
REQ-031 RESP with out_ready=0 SHALL stay in RESP, with in_ready=0.
REQ-032 Upstream signals while in_ready=0 SHALL have no effect.

Reset
REQ-033 reset SHALL force, on the next rising edge: state IDLE; AluA, AluB, out_data = 0; alucontrol, out_rd = 0; out_valid, busy, timeout_err = 0.
REQ-034 reset SHALL override every other input, including mid-EXEC and mid-RESP; any in-flight operation SHALL be dropped with no output.
REQ-035 reset SHALL clear the timeout counter.

Configuration
REQ-036 Macro ALU_ISSUE_TIMEOUT_EN, when defined, SHALL compile in an EXEC cycle counter.
REQ-037 The counter SHALL clear on entry to EXEC.
REQ-038 On the TIMEOUT_CYCLES-th consecutive EXEC cycle without aludone, the block SHALL enter RESP with out_data=0 and set timeout_err.
REQ-039 timeout_err SHALL stay set until reset.
REQ-040 If aludone arrives on the same edge as the timeout, aludone SHALL win: normal capture, timeout_err unchanged.
REQ-041 Without ALU_ISSUE_TIMEOUT_EN, the counter SHALL be absent, timeout_err SHALL be tied to 0, and EXEC SHALL wait indefinitely for aludone.

Verification
REQ-042 Single-cycle op: accept opa=5, opb=3, op=ADD, rd=7; aludone=1 in the first EXEC cycle with alu_result=8 -> out_valid two cycles after accept, out_data=8, out_rd=7.
REQ-043 Multicycle op: accept opa=100, opb=7, op=DIV; aludone held 0 for 33 cycles -> AluA=100 and AluB=7 stable throughout EXEC; out_data=14 on completion.
REQ-044 Backpressure and back-to-back: out_ready=0 for 5 cycles -> out_valid and out_data held, in_ready=0; then out_ready=1 with in_valid=1 -> new op enters EXEC next cycle, no IDLE cycle.
REQ-045 Reset mid-EXEC: assert reset for one cycle during EXEC -> next cycle IDLE, all outputs 0; a late aludone=1 produces no out_valid.
REQ-046 Timeout (macro defined, TIMEOUT_CYCLES=4): aludone held 0 -> RESP after 4 EXEC cycles with out_data=0, timeout_err=1, still 1 after handshake; aludone on the 4th edge instead -> normal capture, timeout_err=0.
